// File: rtl/mos6502s_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mos6502s_loader
//  Description : Byte-stream memory loader for a 6502-style system. While idle,
//                the CPU bus passes straight through to memory. A start request
//                takes over the bus and halts the CPU. Incoming stream bytes are
//                then written to consecutive addresses, one write cycle per byte.
//                Bytes aimed at the ROM half (addr[15]=1) are consumed but not
//                written, and they flag an error. A configurable idle timeout
//                abandons a load whose stream has stalled.
//  Ports       :
//    clk, rst_n                  clock, synchronous active-low reset
//    start, base_addr, length    load request and its parameters
//    s_valid, s_data, s_ready    byte stream handshake
//    cpu_addr/data/rw/cs         CPU-side bus (used only while idle)
//    mem_addr/data/rw/cs         memory-side bus
//    cpu_halt, busy              high while the loader owns the bus
//    done                        one-cycle completion pulse
//    err                         sticky error (ROM target or timeout)
//    bytes_loaded                number of bytes actually written
//  Revision    : 1.0 - initial release
// ============================================================================
module mos6502s_loader #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [15:0] length,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_rw,
    input  logic        cpu_cs,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_rw,
    output logic        mem_cs,
    output logic        cpu_halt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] bytes_loaded
);

    localparam logic [15:0] c_timeout    = 16'(TIMEOUT);
    localparam bit          c_timeout_en = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_ptr;
    logic [15:0] r_count;
    logic [15:0] r_idle;
    logic [15:0] r_bytes;
    logic        r_err;
    logic [7:0]  r_data;

    logic        w_own;
    logic        w_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 16'd0;
            r_count <= 16'd0;
            r_idle  <= 16'd0;
            r_bytes <= 16'd0;
            r_err   <= 1'b0;
            r_data  <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ptr   <= base_addr;
                        r_count <= length;
                        r_bytes <= 16'd0;
                        r_err   <= 1'b0;
                        r_idle  <= 16'd0;
                        r_state <= (length == 16'd0) ? ST_FINISH : ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (s_valid) begin
                        r_idle <= 16'd0;
                        if (!r_ptr[15]) begin
                            r_data  <= s_data;
                            r_state <= ST_WRITE;
                        end else begin
                            // ROM target: swallow the byte, skip the write cycle,
                            // but still advance through the image.
                            r_err   <= 1'b1;
                            r_ptr   <= r_ptr + 16'd1;
                            r_count <= r_count - 16'd1;
                            r_state <= (r_count == 16'd1) ? ST_FINISH : ST_LOAD;
                        end
                    end else begin
                        r_idle <= r_idle + 16'd1;
                        // The cycle that makes the count reach TIMEOUT ends the load.
                        if (c_timeout_en && (r_idle + 16'd1 == c_timeout)) begin
                            r_err   <= 1'b1;
                            r_state <= ST_FINISH;
                        end
                    end
                end

                ST_WRITE: begin
                    r_ptr   <= r_ptr + 16'd1;
                    r_count <= r_count - 16'd1;
                    r_bytes <= r_bytes + 16'd1;
                    r_state <= (r_count == 16'd1) ? ST_FINISH : ST_LOAD;
                end

                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_own   = (r_state != ST_IDLE);
    assign w_write = (r_state == ST_WRITE);

    // Outside IDLE the memory bus is driven purely from loader registers and
    // state; the CPU inputs are muxed out entirely.
    assign mem_addr = w_own ? r_ptr   : cpu_addr;
    assign mem_data = w_own ? r_data  : cpu_data;
    assign mem_cs   = w_own ? w_write : cpu_cs;
    assign mem_rw   = w_own ? ~w_write : cpu_rw;

    assign s_ready      = (r_state == ST_LOAD);
    assign done         = (r_state == ST_FINISH);
    assign busy         = w_own;
    assign cpu_halt     = w_own;
    assign err          = r_err;
    assign bytes_loaded = r_bytes;

endmodule
`default_nettype wire

// File: tb/tb_mos6502s_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mos6502s_loader
//  Description : Self-checking bench for mos6502s_loader (TIMEOUT=8). It uses
//                hand-derived load vectors, directed reset/timeout sequences
//                and randomized loads that are checked against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mos6502s_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_rw;
    logic        cpu_cs;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_rw;
    logic        mem_cs;
    logic        cpu_halt;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] bytes_loaded;

    mos6502s_loader #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_rw       (cpu_rw),
        .cpu_cs       (cpu_cs),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_rw       (mem_rw),
        .mem_cs       (mem_cs),
        .cpu_halt     (cpu_halt),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .bytes_loaded (bytes_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    typedef struct {
        logic [15:0] base;
        int          len;
        logic [31:0] bytes;
        int          n_wr;
        logic        e;
        logic [15:0] nb;
        int          done_at;
        logic [15:0] wr0_a;
        logic [7:0]  wr0_d;
    } vec_t;

    int          checks;
    int          failures;
    int          win;
    int          done_cnt;
    int          done_cyc;
    int          p_low;
    int          low_run;
    bit          rec;
    wr_t         wr_q[$];
    wr_t         exp_q[$];
    logic [7:0]  stream_q[$];
    logic [7:0]  data_q[$];
    logic        exp_err;
    logic [15:0] exp_nb;
    logic        prev_err;
    vec_t        tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge, record memory writes and done pulses
    // for the current load window, then drive the stream and CPU bus.
    task automatic cycle();
        @(negedge clk);
        win++;
        if (rec) begin
            if (mem_cs && !mem_rw) wr_q.push_back('{mem_addr, mem_data, win});
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = win;
            end
            // Hostile CPU bus: any leak through the mux shows up as a write.
            cpu_addr = 16'($urandom);
            cpu_data = 8'($urandom);
            cpu_rw   = 1'b0;
            cpu_cs   = 1'b1;
        end
        if (stream_q.size() > 0 && (low_run >= 3 || $urandom_range(99) >= p_low)) begin
            s_valid = 1'b1;
            s_data  = stream_q[0];
            low_run = 0;
        end else begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            if (stream_q.size() > 0) low_run++;
        end
        #1;
        if (s_valid && s_ready) void'(stream_q.pop_front());
    endtask

    task automatic idle_check(input string name);
        cpu_addr = 16'($urandom);
        cpu_data = 8'($urandom);
        cpu_rw   = 1'($urandom);
        cpu_cs   = 1'($urandom);
        #1;
        chk({name, "_addr"}, mem_addr, cpu_addr);
        chk({name, "_data"}, mem_data, cpu_data);
        chk({name, "_rw"},   mem_rw,   cpu_rw);
        chk({name, "_cs"},   mem_cs,   cpu_cs);
    endtask

    task automatic reset_outputs(input string name);
        chk({name, "_s_ready"}, s_ready, 0);
        chk({name, "_busy"},    busy, 0);
        chk({name, "_halt"},    cpu_halt, 0);
        chk({name, "_done"},    done, 0);
        chk({name, "_err"},     err, 0);
        chk({name, "_bytes"},   bytes_loaded, 0);
        chk({name, "_pt_addr"}, mem_addr, cpu_addr);
        chk({name, "_pt_cs"},   mem_cs, cpu_cs);
    endtask

    // Reference: byte i goes to (base+i) mod 2^16; RAM targets are written,
    // any ROM target flags an error; bytes_loaded counts RAM writes.
    task automatic model_run(input logic [15:0] base, input int len);
        exp_q.delete();
        exp_err = 1'b0;
        exp_nb  = 16'd0;
        for (int i = 0; i < len; i++) begin
            logic [15:0] a;
            a = base + 16'(i);
            if (a[15]) exp_err = 1'b1;
            else begin
                exp_q.push_back('{a, data_q[i], 0});
                exp_nb = exp_nb + 16'd1;
            end
        end
    endtask

    task automatic run_load(input logic [15:0] base, input int len, input int plow, input bit bstart);
        wr_q.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        p_low     = plow;
        low_run   = 0;
        win       = 0;
        cpu_cs    = 1'b1;
        cpu_rw    = 1'b0;
        base_addr = base;
        length    = 16'(len);
        start     = 1'b1;
        s_valid   = 1'b0;
        rec       = 1'b1;
        cycle();
        start = 1'b0;
        while (done_cnt == 0 && win < 400) begin
            if (bstart && win == 2) begin
                start     = 1'b1;
                base_addr = 16'($urandom);
                length    = 16'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            cycle();
        end
        start  = 1'b0;
        rec    = 1'b0;
        cpu_cs = 1'b0;
        cpu_rw = 1'b1;
        chk("done_seen_once", done_cnt, 1);
        cycle();
        chk("busy_after_done", busy, 0);
        chk("halt_after_done", cpu_halt, 0);
        chk("done_single_pulse", done, 0);
        chk("s_ready_idle", s_ready, 0);
    endtask

    task automatic compare_run();
        chk("n_writes", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            chk("wr_addr", wr_q[i].a, exp_q[i].a);
            chk("wr_data", wr_q[i].d, exp_q[i].d);
        end
        chk("err", err, exp_err);
        chk("bytes_loaded", bytes_loaded, exp_nb);
        chk("stream_consumed", stream_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rec      = 1'b0;
        low_run  = 0;
        p_low    = 0;
        win      = 0;

        tbl[0] = '{16'h7FFF, 2, 32'h0000_2211, 1, 1'b1, 16'd1, 4, 16'h7FFF, 8'h11};
        tbl[1] = '{16'h0200, 3, 32'h0000_42A9, 3, 1'b0, 16'd3, 7, 16'h0200, 8'hA9};
        tbl[2] = '{16'hFFFF, 2, 32'h0000_4433, 1, 1'b1, 16'd1, 4, 16'h0000, 8'h44};
        tbl[3] = '{16'h1234, 0, 32'h0000_0000, 0, 1'b0, 16'd0, 1, 16'h0000, 8'h00};
        tbl[4] = '{16'h8000, 3, 32'h0003_0201, 0, 1'b1, 16'd0, 4, 16'h0000, 8'h00};

        // Reset with a start request and stream data present.
        rst_n     = 1'b0;
        start     = 1'b1;
        base_addr = 16'h1111;
        length    = 16'd5;
        s_valid   = 1'b1;
        s_data    = 8'hEE;
        cpu_addr  = 16'h8123;
        cpu_data  = 8'h5C;
        cpu_rw    = 1'b0;
        cpu_cs    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            reset_outputs("rst");
        end
        rst_n   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        reset_outputs("post_rst");

        for (int i = 0; i < 4; i++) begin
            idle_check("idle_pt");
            cycle();
        end

        // Reset in the middle of a 5-byte load, after two writes.
        stream_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        wr_q.delete();
        p_low     = 0;
        low_run   = 0;
        done_cnt  = 0;
        win       = 0;
        rec       = 1'b1;
        cpu_cs    = 1'b1;
        cpu_rw    = 1'b0;
        base_addr = 16'h0300;
        length    = 16'd5;
        start     = 1'b1;
        s_valid   = 1'b0;
        cycle();
        start = 1'b0;
        while (win < 5) cycle();
        rst_n    = 1'b0;
        rec      = 1'b0;
        cpu_cs   = 1'b0;
        cpu_rw   = 1'b1;
        cpu_addr = 16'h4321;
        cpu_data = 8'h77;
        cycle();
        chk("midrst_busy",    busy, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_halt",    cpu_halt, 0);
        chk("midrst_bytes",   bytes_loaded, 0);
        chk("midrst_err",     err, 0);
        chk("midrst_done",    done, 0);
        chk("midrst_mem_cs",  mem_cs, 0);
        chk("midrst_pt_addr", mem_addr, 16'h4321);
        chk("midrst_pt_data", mem_data, 8'h77);
        chk("midrst_n_writes", wr_q.size(), 2);
        if (wr_q.size() >= 2) begin
            chk("midrst_wr0_addr", wr_q[0].a, 16'h0300);
            chk("midrst_wr0_data", wr_q[0].d, 8'h10);
            chk("midrst_wr1_addr", wr_q[1].a, 16'h0301);
            chk("midrst_wr1_data", wr_q[1].d, 8'h20);
        end
        rst_n = 1'b1;
        stream_q.delete();
        repeat (3) begin
            cycle();
            chk("midrst_no_write", mem_cs, 0);
            chk("midrst_still_idle", busy, 0);
        end

        // Table-driven loads with the stream always valid.
        prev_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle_check("tbl_idle_pt");
            cycle();
            chk("err_sticky", err, prev_err);
            data_q.delete();
            for (int j = 0; j < tbl[i].len; j++) data_q.push_back(tbl[i].bytes[8*j +: 8]);
            stream_q = data_q;
            model_run(tbl[i].base, tbl[i].len);
            run_load(tbl[i].base, tbl[i].len, 0, 1'b0);
            compare_run();
            chk("tbl_n_writes", wr_q.size(), tbl[i].n_wr);
            chk("tbl_err", err, tbl[i].e);
            chk("tbl_bytes", bytes_loaded, tbl[i].nb);
            chk("tbl_done_cycle", done_cyc, tbl[i].done_at);
            if (tbl[i].n_wr > 0 && wr_q.size() > 0) begin
                chk("tbl_wr0_addr", wr_q[0].a, tbl[i].wr0_a);
                chk("tbl_wr0_data", wr_q[0].d, tbl[i].wr0_d);
            end
            for (int j = 1; j < wr_q.size(); j++)
                chk("tbl_write_spacing", wr_q[j].c - wr_q[j-1].c, 2);
            prev_err = tbl[i].e;
        end

        // Timeout: one byte of four arrives, then the stream goes quiet.
        stream_q = '{8'h5A};
        run_load(16'h0400, 4, 0, 1'b0);
        chk("to_n_writes", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            chk("to_wr_addr", wr_q[0].a, 16'h0400);
            chk("to_wr_data", wr_q[0].d, 8'h5A);
        end
        chk("to_err", err, 1);
        chk("to_bytes", bytes_loaded, 1);
        chk("to_done_cycle", done_cyc, 11);
        chk("to_stream", stream_q.size(), 0);

        // Start pulsed while busy must not disturb the load in progress.
        data_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        stream_q = data_q;
        model_run(16'h1000, 4);
        run_load(16'h1000, 4, 0, 1'b1);
        compare_run();
        chk("busy_start_done_cycle", done_cyc, 9);

        // Randomized loads against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] base;
            int          len;
            int          sel;
            sel = $urandom_range(2);
            if (sel == 0)      base = 16'($urandom);
            else if (sel == 1) base = 16'h7FF0 + 16'($urandom_range(15));
            else               base = 16'hFFF0 + 16'($urandom_range(15));
            len = $urandom_range(20);
            data_q.delete();
            for (int j = 0; j < len; j++) data_q.push_back(8'($urandom));
            stream_q = data_q;
            model_run(base, len);
            run_load(base, len, $urandom_range(60), 1'($urandom_range(1)));
            compare_run();
            idle_check("rnd_idle_pt");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
